// File: rtl/dcache_controller.sv
// Direct-mapped read-only data cache controller: tag/valid/data arrays, lookup,
// block refill from word-addressed memory, and saturating access/hit counters.
module dcache_controller #(
    parameter int ADDR_W      = 15,
    parameter int INDEX_W     = 8,
    parameter int MEM_LATENCY = 4,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              flush,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ready,
    output logic              cpu_hit,
    output logic              busy,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_w3,
    input  logic [31:0]       mem_w2,
    input  logic [31:0]       mem_w1,
    input  logic [31:0]       mem_w0,
    output logic [CNT_W-1:0]  access_count,
    output logic [CNT_W-1:0]  hit_count
);
    localparam int TAG_W = ADDR_W - INDEX_W - 2;
    localparam int LINES = 1 << INDEX_W;
    localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAST = LAT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, COMPARE, MEM_WAIT, REFILL} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LAT_W-1:0]    cnt_q, cnt_d;
    logic [LINES-1:0]    valid_q, valid_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                ready_q, ready_d;
    logic                hit_q, hit_d;
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   maddr_q, maddr_d;
    logic [CNT_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    hitc_q, hitc_d;

    logic [TAG_W-1:0]    tag_mem  [LINES];
    logic [3:0][31:0]    data_mem [LINES];

    logic [INDEX_W-1:0]  idx;
    logic [TAG_W-1:0]    tag;
    logic [1:0]          off;
    logic                lookup_hit;
    logic [3:0][31:0]    blk;

    assign idx        = addr_q[INDEX_W+1:2];
    assign tag        = addr_q[ADDR_W-1:INDEX_W+2];
    assign off        = addr_q[1:0];
    assign lookup_hit = valid_q[idx] && (tag_mem[idx] == tag);
    assign blk        = {mem_w3, mem_w2, mem_w1, mem_w0};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        hit_d   = 1'b0;
        rd_en_d = rd_en_q;
        maddr_d = maddr_q;
        acc_d   = acc_q;
        hitc_d  = hitc_q;
        unique case (state_q)
            IDLE: begin
                // flush wins over a simultaneous request, which is simply dropped
                if (flush) begin
                    valid_d = '0;
                end else if (cpu_req) begin
                    addr_d  = cpu_addr;
                    acc_d   = (&acc_q) ? acc_q : acc_q + 1'b1;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (lookup_hit) begin
                    rdata_d = data_mem[idx][off];
                    ready_d = 1'b1;
                    hit_d   = 1'b1;
                    hitc_d  = (&hitc_q) ? hitc_q : hitc_q + 1'b1;
                    state_d = IDLE;
                end else begin
                    maddr_d = {addr_q[ADDR_W-1:2], 2'b00};
                    rd_en_d = 1'b1;
                    cnt_d   = '0;
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = REFILL;
            end
            REFILL: begin
                valid_d[idx] = 1'b1;
                rdata_d      = blk[off];
                ready_d      = 1'b1;
                rd_en_d      = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            valid_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            hit_q   <= 1'b0;
            rd_en_q <= 1'b0;
            maddr_q <= '0;
            acc_q   <= '0;
            hitc_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            hit_q   <= hit_d;
            rd_en_q <= rd_en_d;
            maddr_q <= maddr_d;
            acc_q   <= acc_d;
            hitc_q  <= hitc_d;
        end
    end

    // Tag/data storage carries no reset; a reset during refill leaves state IDLE so nothing is written
    always_ff @(posedge clk) begin
        if (state_q == REFILL) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= blk;
        end
    end

    assign cpu_rdata    = rdata_q;
    assign cpu_ready    = ready_q;
    assign cpu_hit      = hit_q;
    assign busy         = (state_q != IDLE);
    assign mem_rd_en    = rd_en_q;
    assign mem_addr     = maddr_q;
    assign access_count = acc_q;
    assign hit_count    = hitc_q;
endmodule
